// File: rtl/morse_transmissor_pkg.sv
// Shared types and the digit-to-Morse lookup for the Morse transmitter.
// Patterns are MSB first: bit 4 is keyed first, 1 = dash, 0 = dot.
package morse_transmissor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP,
    CGAP
  } state_e;

  localparam logic [3:0] MAX_DIGIT = 4'd9;

  function automatic logic is_digit(input logic [3:0] value);
    return value <= MAX_DIGIT;
  endfunction

  // Values above 9 map to all-dots; they never reach the FIFO anyway.
  function automatic logic [4:0] digit_to_morse(input logic [3:0] digit);
    logic [4:0] pattern;
    case (digit)
      4'd0:    pattern = 5'b11111;
      4'd1:    pattern = 5'b01111;
      4'd2:    pattern = 5'b00111;
      4'd3:    pattern = 5'b00011;
      4'd4:    pattern = 5'b00001;
      4'd5:    pattern = 5'b00000;
      4'd6:    pattern = 5'b10000;
      4'd7:    pattern = 5'b11000;
      4'd8:    pattern = 5'b11100;
      4'd9:    pattern = 5'b11110;
      default: pattern = 5'b00000;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/morse_fifo.sv
// Synchronous FIFO buffering digits between the handshake and the keyer.
// An explicit occupancy counter separates full from empty when the pointers meet.
module morse_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   nivel_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign nivel_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // NOTE: storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/morse_transmissor.sv
// Buffers decimal digits and keys their Morse patterns out on a serial line,
// with dot, dash and gap lengths expressed in multiples of UNIT_CYCLES.
module morse_transmissor
  import morse_transmissor_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES    = 12500000,
  parameter int unsigned DASH_UNITS     = 3,
  parameter int unsigned ELEM_GAP_UNITS = 1,
  parameter int unsigned CHAR_GAP_UNITS = 3,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [3:0]                    num,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          erro,
  output logic                          sinal,
  output logic                          ponto,
  output logic                          traco,
  output logic [4:0]                    morse,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   nivel
);

  localparam int unsigned MAX_UNITS =
    (DASH_UNITS >= ELEM_GAP_UNITS && DASH_UNITS >= CHAR_GAP_UNITS) ? DASH_UNITS :
    (ELEM_GAP_UNITS >= CHAR_GAP_UNITS) ? ELEM_GAP_UNITS : CHAR_GAP_UNITS;
  localparam int unsigned CNT_W = $clog2(MAX_UNITS * UNIT_CYCLES + 1);

  // Counter loads hold duration-1 so the state lasts exactly its duration.
  localparam logic [CNT_W-1:0] DOT_TICKS  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_TICKS = CNT_W'(DASH_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ELEM_TICKS = CNT_W'(ELEM_GAP_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CGAP_TICKS = CNT_W'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [3:0]        fifo_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              push;
  logic              pop;
  logic [4:0]        next_pat;
  logic [2:0]        next_idx;

  state_e            state_q;
  logic [2:0]        idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [4:0]        morse_q;
  logic              sinal_q;
  logic              ponto_q;
  logic              traco_q;
  logic              busy_q;
  logic              done_q;
  logic              erro_q;

  function automatic logic [CNT_W-1:0] elem_ticks(input logic is_dash);
    return is_dash ? DASH_TICKS : DOT_TICKS;
  endfunction

  assign in_ready = ~fifo_full;
  assign accept   = in_valid & in_ready;
  assign push     = accept & is_digit(num);
  assign next_pat = digit_to_morse(fifo_data);
  assign next_idx = idx_q - 3'd1;

  // A new character starts from IDLE, or straight out of the last char-gap
  // cycle so back-to-back characters have no idle cycle between them.
  assign pop = ~fifo_empty &
               ((state_q == IDLE) | ((state_q == CGAP) & (cnt_q == '0)));

  morse_fifo #(
    .WIDTH (4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset_n),
    .push_i  (push),
    .data_i  (num),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .nivel_o (nivel)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      erro_q <= 1'b0;
    end else begin
      erro_q <= accept & ~is_digit(num);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      morse_q <= '0;
      sinal_q <= 1'b0;
      ponto_q <= 1'b0;
      traco_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pop) begin
        state_q <= ON;
        morse_q <= next_pat;
        idx_q   <= 3'd4;
        cnt_q   <= elem_ticks(next_pat[4]);
        sinal_q <= 1'b1;
        ponto_q <= ~next_pat[4];
        traco_q <= next_pat[4];
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            busy_q <= 1'b0;
          end
          ON: begin
            if (cnt_q == '0) begin
              sinal_q <= 1'b0;
              ponto_q <= 1'b0;
              traco_q <= 1'b0;
              if (idx_q != '0) begin
                state_q <= GAP;
                cnt_q   <= ELEM_TICKS;
              end else begin
                state_q <= CGAP;
                cnt_q   <= CGAP_TICKS;
                done_q  <= (CGAP_TICKS == '0);
              end
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          GAP: begin
            if (cnt_q == '0) begin
              state_q <= ON;
              idx_q   <= next_idx;
              cnt_q   <= elem_ticks(morse_q[next_idx]);
              sinal_q <= 1'b1;
              ponto_q <= ~morse_q[next_idx];
              traco_q <= morse_q[next_idx];
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          CGAP: begin
            if (cnt_q == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q  <= cnt_q - CNT_ONE;
              // done marks the final char-gap cycle.
              done_q <= (cnt_q == CNT_ONE);
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign erro  = erro_q;
  assign sinal = sinal_q;
  assign ponto = ponto_q;
  assign traco = traco_q;
  assign morse = morse_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_morse_transmissor.sv
// Bench for morse_transmissor: directed scenarios plus random traffic, every
// cycle compared against a per-character waveform model built from the digit table.
module tb_morse_transmissor;

  localparam int UNIT   = 2;
  localparam int DASH   = 3;
  localparam int EGAP   = 1;
  localparam int CGAP_U = 3;
  localparam int DEPTH  = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] num = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       erro;
  logic       sinal;
  logic       ponto;
  logic       traco;
  logic [4:0] morse;
  logic       busy;
  logic       done;
  logic [2:0] nivel;

  morse_transmissor #(
    .UNIT_CYCLES    (UNIT),
    .DASH_UNITS     (DASH),
    .ELEM_GAP_UNITS (EGAP),
    .CHAR_GAP_UNITS (CGAP_U),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .num      (num),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .erro     (erro),
    .sinal    (sinal),
    .ponto    (ponto),
    .traco    (traco),
    .morse    (morse),
    .busy     (busy),
    .done     (done),
    .nivel    (nivel)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic s;
    logic p;
    logic t;
    logic d;
  } slot_t;

  logic [4:0] code_tbl [10];
  int         digit_q [$];
  slot_t      wave_q [$];
  logic [4:0] m_morse;
  logic       m_erro;

  int vectors = 0;
  int miscompares = 0;
  int busy_cycles, done_cycles, done_at, erro_cycles, max_nivel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic append(input int cycles, input slot_t s);
    repeat (cycles) wave_q.push_back(s);
  endtask

  // Whole character as a cycle-by-cycle list of key/indicator/done values.
  task automatic build_char(input int d);
    logic [4:0] c;
    logic       dash;
    slot_t      on;
    slot_t      last;
    c = code_tbl[d];
    last = '{s: 1'b0, p: 1'b0, t: 1'b0, d: 1'b1};
    for (int i = 4; i >= 0; i--) begin
      dash = c[i];
      on = '{s: 1'b1, p: ~dash, t: dash, d: 1'b0};
      append(dash ? DASH * UNIT : UNIT, on);
      if (i > 0) begin
        append(EGAP * UNIT, '0);
      end else begin
        append(CGAP_U * UNIT - 1, '0);
        append(1, last);
      end
    end
  endtask

  task automatic model_reset();
    digit_q.delete();
    wave_q.delete();
    m_morse = '0;
    m_erro  = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [3:0] n);
    logic rdy;
    int   d;
    rdy = (digit_q.size() < DEPTH);
    if (wave_q.size() > 0) void'(wave_q.pop_front());
    if (wave_q.size() == 0 && digit_q.size() > 0) begin
      d = digit_q.pop_front();
      build_char(d);
      m_morse = code_tbl[d];
    end
    m_erro = v && rdy && (n > 4'd9);
    if (v && rdy && n <= 4'd9) digit_q.push_back(int'(n));
  endtask

  function automatic logic [31:0] expected_vec();
    slot_t cur;
    cur = '0;
    if (wave_q.size() > 0) cur = wave_q[0];
    return {17'd0, cur.s, cur.p, cur.t, logic'(wave_q.size() > 0), cur.d, m_erro,
            logic'(digit_q.size() < DEPTH), 3'(digit_q.size()), m_morse};
  endfunction

  function automatic logic [31:0] observed_vec();
    return {17'd0, sinal, ponto, traco, busy, done, erro, in_ready, nivel, morse};
  endfunction

  task automatic clear_stats();
    busy_cycles = 0;
    done_cycles = 0;
    done_at = 0;
    erro_cycles = 0;
    max_nivel = 0;
  endtask

  task automatic step();
    logic       v;
    logic [3:0] n;
    v = in_valid;
    n = num;
    @(posedge clock);
    model_edge(v, n);
    #1;
    check("outputs", observed_vec(), expected_vec());
    if (busy) busy_cycles++;
    if (done) begin
      done_cycles++;
      done_at = busy_cycles;
    end
    if (erro) erro_cycles++;
    if (int'(nivel) > max_nivel) max_nivel = int'(nivel);
  endtask

  // Leaves in_valid high so consecutive pushes form an unbroken burst.
  task automatic push_digit(input logic [3:0] d, output int waited);
    logic sent;
    sent = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    num = d;
    while (!sent && waited < 400) begin
      sent = (digit_q.size() < DEPTH);
      step();
      waited++;
    end
    check("push_timeout", 32'(!sent), 32'd0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    in_valid = 1'b0;
    while ((wave_q.size() > 0 || digit_q.size() > 0) && k < 2000) begin
      step();
      k++;
    end
    check("idle_timeout", 32'(k >= 2000), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    code_tbl = '{5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001,
                 5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110};
    model_reset();
    #1 reset_n = 1'b0;
    #11;
    check("reset_state", observed_vec(), expected_vec());
    @(negedge clock) reset_n = 1'b1;
    idle(3);

    // Single digit 1: 40 busy cycles, done in the last one.
    clear_stats();
    push_digit(4'd1, w);
    wait_idle();
    idle(2);
    check("d1_busy_len", 32'(busy_cycles), 32'd40);
    check("d1_done_at", 32'(done_at), 32'd40);
    check("d1_done_cnt", 32'(done_cycles), 32'd1);

    // 5 then 0 back to back: 24 + 44 cycles with no idle cycle between.
    clear_stats();
    push_digit(4'd5, w);
    push_digit(4'd0, w);
    wait_idle();
    idle(2);
    check("b2b_busy_len", 32'(busy_cycles), 32'd68);
    check("b2b_done_at", 32'(done_at), 32'd68);
    check("b2b_done_cnt", 32'(done_cycles), 32'd2);

    // Fill: burst of 7,8,9,3,2 reaches full; the sixth push stalls.
    clear_stats();
    push_digit(4'd7, w);
    push_digit(4'd8, w);
    push_digit(4'd9, w);
    push_digit(4'd3, w);
    push_digit(4'd2, w);
    push_digit(4'd6, w);
    check("fill_stall_len", 32'(w), 32'd30);
    wait_idle();
    check("fill_max_nivel", 32'(max_nivel), 32'd4);
    check("fill_done_cnt", 32'(done_cycles), 32'd6);

    // Invalid digit followed by a valid 4.
    clear_stats();
    push_digit(4'd12, w);
    idle(3);
    check("bad_erro_len", 32'(erro_cycles), 32'd1);
    check("bad_no_sinal", 32'(busy_cycles), 32'd0);
    push_digit(4'd4, w);
    wait_idle();

    // Push lands on the CGAP->ON pop edge with two digits queued.
    push_digit(4'd5, w);
    push_digit(4'd5, w);
    push_digit(4'd5, w);
    in_valid = 1'b0;
    w = 0;
    while (wave_q.size() != 1 && w < 200) begin
      step();
      w++;
    end
    check("simul_reach", 32'(w >= 200), 32'd0);
    in_valid = 1'b1;
    num = 4'd9;
    step();
    in_valid = 1'b0;
    check("simul_nivel", 32'(nivel), 32'd2);
    check("simul_ready", 32'(in_ready), 32'd1);
    wait_idle();

    // Reset in the middle of the first dash of digit 0.
    push_digit(4'd0, w);
    in_valid = 1'b0;
    repeat (3) step();
    #3 reset_n = 1'b0;
    model_reset();
    #1;
    check("reset_abort", observed_vec(), expected_vec());
    check("reset_ready", 32'(in_ready), 32'd1);
    #2 reset_n = 1'b1;
    clear_stats();
    idle(10);
    check("reset_no_done", 32'(done_cycles), 32'd0);
    check("reset_stay_idle", 32'(busy_cycles), 32'd0);

    // Random traffic, honouring the hold rule while stalled.
    repeat (2500) begin
      if (!(in_valid && digit_q.size() >= DEPTH)) begin
        in_valid = ($urandom_range(0, 3) == 0);
        num = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                          : 4'($urandom_range(0, 9));
      end
      step();
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/morse_transmissor.md
Name: morse_transmissor

Overview:
- Sequential successor to the combinational digit-to-Morse encoder.
- Accepts decimal digits 0-9 over a valid/ready handshake and buffers them in a parametrised FIFO.
- Looks up each digit's 5-element Morse pattern and keys it out on a serial line with dot, dash and gap timing measured in clock ticks.
- Drives the board LED/buzzer key line plus per-element ponto/traco indicators.

Parameters:
- UNIT_CYCLES, 12500000: clock cycles per Morse time unit; must be >=1.
- DASH_UNITS, 3: dash length in units; a dot is always 1 unit.
- ELEM_GAP_UNITS, 1: key-off time between elements of one character.
- CHAR_GAP_UNITS, 3: key-off time after the last element of a character.
- FIFO_DEPTH, 4: digit buffer depth; must be a power of 2 and >=2.

Ports:
- clock, in, 1: system clock; all state updates on the rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- num, in, 4: digit to transmit.
- in_valid, in, 1: num is valid this cycle.
- in_ready, out, 1: buffer can accept a digit.
- erro, out, 1: one-cycle pulse when a handshaked num is greater than 9.
- sinal, out, 1: key line; 1 while an element is sounding.
- ponto, out, 1: 1 while a dot is sounding.
- traco, out, 1: 1 while a dash is sounding.
- morse, out, 5: pattern of the character being sent; bit 4 is sent first; 1 = dash, 0 = dot.
- busy, out, 1: 1 while a character is in progress, including its trailing char gap.
- done, out, 1: one-cycle pulse at the end of each character's char gap.
- nivel, out, clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset (asynchronous, immediate):
  - FSM goes to IDLE and the FIFO is emptied.
  - Outputs sinal, ponto, traco, morse, busy, done, erro and nivel are all 0.
  - in_ready is 1.
  - A reset mid-character aborts it with no done pulse.
- Handshake:
  - in_ready = (nivel < FIFO_DEPTH).
  - A transfer occurs on a rising edge with in_valid & in_ready.
  - If num <= 9 it is pushed. If num > 9 it is dropped and erro is 1 for the following cycle.
  - The producer must hold num stable while in_valid is high and in_ready is low.
  - A push and a pop on the same edge leave nivel unchanged.
  - When the FIFO is full, in_ready is 0 and no push occurs.
- Digit table, MSB first:
  - 0=11111, 1=01111, 2=00111, 3=00011, 4=00001.
  - 5=00000, 6=10000, 7=11000, 8=11100, 9=11110.
- FSM states: IDLE, ON, GAP, CGAP.
  - IDLE -> ON when the FIFO is non-empty. On that edge: pop, latch morse, element index = 4, load the tick counter, set busy = 1.
  - Latency: a digit accepted at edge k into an idle, empty block raises sinal after edge k+1.
  - ON: sinal = 1, ponto = ~morse[idx], traco = morse[idx].
    - Lasts UNIT_CYCLES cycles for a dot, DASH_UNITS*UNIT_CYCLES cycles for a dash.
    - Exits to GAP if idx > 0, otherwise to CGAP.
  - GAP: all key outputs 0 for ELEM_GAP_UNITS*UNIT_CYCLES cycles; then idx decrements and the FSM returns to ON.
  - CGAP: key outputs 0 for CHAR_GAP_UNITS*UNIT_CYCLES cycles.
    - On the exit edge, done pulses for 1 cycle.
    - If the FIFO is non-empty, the FSM goes directly to ON with the next pop and busy stays 1; there is no IDLE cycle between characters.
    - Otherwise it goes to IDLE and busy = 0.
- Tick counter:
  - Single down-counter, width clog2(max(DASH_UNITS, ELEM_GAP_UNITS, CHAR_GAP_UNITS) * UNIT_CYCLES + 1).
  - Loaded with duration-1 on state entry; the FSM advances when the count reaches 0.
- morse holds its value after the character ends, until the next load.
- ponto and traco are never 1 simultaneously.
- ponto and traco are both 0 whenever sinal = 0.
- FIFO pointers wrap modulo FIFO_DEPTH; occupancy tracking must distinguish full from empty.

Decomposition:
- Include file morse_defs.vh:
  - FSM state localparams.
  - Function digit_to_morse(input [3:0]) returning [4:0], with 00000 for values >9.
- Sub-module morse_fifo: synchronous FIFO parametrised on WIDTH=4 and DEPTH, with push/pop/full/empty/nivel and asynchronous active-low reset.
- Timing FSM and counter live in the top module.

Test Plan:
All scenarios use UNIT_CYCLES=2, DASH_UNITS=3, ELEM_GAP_UNITS=1, CHAR_GAP_UNITS=3, FIFO_DEPTH=4.
- Reset: assert reset_n=0 mid-dash of digit 0 -> sinal, ponto, traco, busy, nivel, morse are all 0 immediately and in_ready=1; after release, no done pulse and the FSM stays IDLE.
- Single digit 1: sinal sequence is on2/off2 then on6/off2 three times, then on6/off6; busy is high for 40 cycles; done pulses on cycle 40; morse=01111; ponto is high only in the first on-window.
- Digits 5 then 0 sent back-to-back: 5 takes 24 cycles (all ponto), then 0 starts immediately with no idle cycle, takes 44 cycles (all traco), and done pulses twice.
- Fill: push 7,8,9,3,2 with in_valid held high while idle -> first digit pops immediately, the next four fill the FIFO, nivel peaks at 4, in_ready drops to 0, the 6th push stalls until the first char gap ends; output order is 7,8,9,3,2.
- Invalid digit: push num=12 -> erro=1 for exactly 1 cycle, nivel unchanged, no sinal activity; a following push of 4 is sent as 00001.
- Simultaneous events: push on the same edge as the CGAP->ON pop with nivel=2 -> nivel stays 2 and in_ready stays high.
